// File: rtl/expr_pkg.sv
// expr_pkg: FSM state and character-class enums plus ASCII constants shared by expr_stream_checker and expr_char_class
package expr_pkg;
  typedef enum logic [1:0] {S_EXP, S_NUM, S_CLS, S_ERR} state_t;
  typedef enum logic [2:0] {DIG, OP, LP, RP, BAD} cls_t;
  localparam logic [7:0] A_0   = 8'h30;
  localparam logic [7:0] A_9   = 8'h39;
  localparam logic [7:0] A_ADD = 8'h2B;
  localparam logic [7:0] A_SUB = 8'h2D;
  localparam logic [7:0] A_MUL = 8'h2A;
  localparam logic [7:0] A_DIV = 8'h2F;
  localparam logic [7:0] A_LP  = 8'h28;
  localparam logic [7:0] A_RP  = 8'h29;
endpackage

// File: rtl/expr_char_class.sv
// expr_char_class: combinational classifier in[DATA_W] -> cls (DIG/OP/LP/RP/BAD); parens are BAD unless EXPR_PAREN_EN is defined
module expr_char_class
  import expr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] in,
  output cls_t              cls
);
`ifdef EXPR_PAREN_EN
  localparam bit PAREN = 1'b1;
`else
  localparam bit PAREN = 1'b0;
`endif
  logic [7:0] c;
  logic       hi;
  assign c  = in[7:0];
  assign hi = (in >> 8) != '0;
  assign cls = hi                                                   ? BAD :
               (c >= A_0 && c <= A_9)                               ? DIG :
               (c == A_ADD || c == A_SUB || c == A_MUL || c == A_DIV) ? OP  :
               (PAREN && c == A_LP)                                 ? LP  :
               (PAREN && c == A_RP)                                 ? RP  : BAD;
endmodule

// File: rtl/expr_stream_checker.sv
// expr_stream_checker: per-character ASCII expression validator (clk, clr async; in_valid, in -> out legal-complete, err sticky, depth open parens); parens enabled by EXPR_PAREN_EN
module expr_stream_checker
  import expr_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DEPTH  = 4,
  parameter int MAX_DIGITS = 4,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  cls_t               cls;
  state_t             st, ns;
  logic [DEPTH_W-1:0] dep, nd;
  logic [CNT_W-1:0]   cnt, nc;
  expr_char_class #(.DATA_W(DATA_W)) u_cls (.in(in), .cls(cls));
  always_comb begin
    ns = st;
    nd = dep;
    nc = cnt;
    case (st)
      S_EXP:
        if (cls == DIG) begin
          ns = S_NUM;
          nc = CNT_W'(1);
        end else if (cls == LP && dep != DEPTH_W'(MAX_DEPTH)) nd = dep + 1'b1;
        else ns = S_ERR;
      S_NUM, S_CLS:
        if (cls == OP) ns = S_EXP;
        else if (cls == RP && dep != '0) begin
          ns = S_CLS;
          nd = dep - 1'b1;
        end else if (st == S_NUM && cls == DIG && cnt != CNT_W'(MAX_DIGITS)) nc = cnt + 1'b1;
        else ns = S_ERR;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      st  <= S_EXP;
      dep <= '0;
      cnt <= '0;
      out <= 1'b0;
      err <= 1'b0;
    end else if (in_valid) begin
      st  <= ns;
      dep <= nd;
      cnt <= nc;
      out <= (ns == S_NUM || ns == S_CLS) && nd == '0;
      err <= ns == S_ERR;
    end
`ifdef EXPR_PAREN_EN
  assign depth = dep;
`else
  assign depth = '0;
`endif
endmodule

// File: doc/expr_stream_checker.md
# expr_stream_checker

Streaming validator for ASCII arithmetic expressions, one character per accepted cycle. It generalises the single-digit `digit (op digit)*` checker to:

- multi-digit operands,
- four operators,
- optional nested parentheses with a parametrised depth limit,
- a valid qualifier and a sticky error flag.

It sits after the serial character source and reports on every accepted character whether the prefix consumed so far is a complete, legal expression.

## Interface
- DATA_W, 8, character width (≥ 8); bits above [7:0] must be zero for a legal character.
- MAX_DEPTH, 4, maximum parenthesis nesting (≥ 1).
- MAX_DIGITS, 4, maximum digits per operand (≥ 1).
- DEPTH_W, $clog2(MAX_DEPTH+1), derived width of depth.
- clk  in  1  clock, rising edge.
- clr  in  1  reset: asynchronous, active-high; clock: clk.
- in_valid  in  1  character on `in` is consumed this edge.
- in  in  DATA_W  ASCII character.
- out  out  1  consumed prefix is a complete legal expression.
- err  out  1  sticky: prefix can never become legal.
- depth  out  DEPTH_W  current open-parenthesis count.

## Operation
- Character classes (from in[7:0], upper bits zero):
  - DIG: '0'–'9' (0x30–0x39)
  - OP: '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F
  - LP: '(' 0x28
  - RP: ')' 0x29
  - BAD: everything else, including any nonzero upper bit.
- States: S_EXP (expect operand; reset state), S_NUM (inside operand), S_CLS (after ')'), S_ERR (absorbing).
- S_EXP:
  - DIG → S_NUM, digit count = 1.
  - LP → depth+1, stay S_EXP; if depth == MAX_DEPTH → S_ERR.
  - Any other class → S_ERR.
- S_NUM:
  - DIG → count+1; if count == MAX_DIGITS → S_ERR.
  - OP → S_EXP.
  - RP → if depth == 0 → S_ERR, else depth−1 → S_CLS.
  - LP or BAD → S_ERR.
- S_CLS:
  - OP → S_EXP.
  - RP → same rule as in S_NUM.
  - DIG, LP or BAD → S_ERR.
- S_ERR: held until clr; ignores all input.
- out = 1 iff the next state is S_NUM or S_CLS and the next depth is 0.
- err = 1 iff the next state is S_ERR.
- Both outputs are registered on the accepting edge.
- Leading zeros are legal.
- Unary minus is illegal: '-' in S_EXP → S_ERR.
- Digit count and depth never wrap; the overflow cases go to S_ERR before any wrap.

## Timing
- Reset values: state S_EXP, out 0, err 0, depth 0, digit count 0.
- Latency: out, err and depth reflect the character accepted at edge N immediately after edge N (1-cycle registered).
- in_valid = 0: state, counters and all outputs hold.
- No backpressure; every valid character is consumed.
- clr mid-expression: immediate asynchronous return to reset values. The first character after clr deasserts is treated as the first character of a new expression.
- clr and in_valid asserted together: clr wins and the character is dropped.
- Once err = 1, out stays 0 and depth freezes until clr.

## Configuration
- EXPR_PAREN_EN defined: LP/RP handled as above and depth is live.
- EXPR_PAREN_EN undefined:
  - LP and RP are classed BAD (→ S_ERR).
  - S_CLS is unreachable.
  - depth is tied to 0.
  - MAX_DEPTH is ignored.
  - Port list is unchanged.

## Structure
- Package expr_pkg holds:
  - state enum (S_EXP, S_NUM, S_CLS, S_ERR)
  - char-class enum (DIG, OP, LP, RP, BAD)
  - ASCII constants for the classed characters.
- Sub-module expr_char_class: a combinational DATA_W → class decoder, honouring EXPR_PAREN_EN.
- The top holds the FSM, depth counter and digit counter.

## Test plan
- "1+23*4" with in_valid = 1 every cycle → out 1,0,1,1,0,1; err stays 0.
- "(1+2)*3" with PAREN_EN → depth 1,1,1,1,0,0,0; out 0,0,0,0,1,0,1.
- ")" as first character, then "1" → err = 1 after edge 1; stays 1 and out stays 0 after "1".
- MAX_DEPTH = 2, "(((" → depth 1,2, then err = 1 on the third.
- MAX_DIGITS = 4, "12345" → out 1,1,1,1, then err = 1 on '5'.
- "7+" with in_valid gaps, then clr pulse mid-cycle, then "9" → outputs hold during gaps; after clr all outputs 0; after "9" out = 1.
